pkt_rx_parser: RTL



---
 rtl/config_pkg.sv | 45 ++++
 rtl/pkt_rx_parser.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/config_pkg.sv
//------------------------------------------------------------------------------
// config_pkg
//   Shared opcode constants, parser state encoding and packet header size
//   for the UART packet front-end.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package config_pkg;

   // Opcodes understood by the arithmetic/echo core
   localparam logic [7:0] OPCODE_ECHO = 8'h01;
   localparam logic [7:0] OPCODE_ADD  = 8'h02;
   localparam logic [7:0] OPCODE_MUL  = 8'h03;
   localparam logic [7:0] OPCODE_DIV  = 8'h04;

   // Header is opcode, reserved, length LSB, length MSB
   localparam int HDR_BYTES = 4;

   typedef enum logic [2:0] {
      P_OPCODE  = 3'd0,
      P_RSVD    = 3'd1,
      P_LEN_LSB = 3'd2,
      P_LEN_MSB = 3'd3,
      P_HDR     = 3'd4,
      P_PAYLOAD = 3'd5,
      P_WORD    = 3'd6,
      P_DROP    = 3'd7
   } parser_state_t;

   // True for opcodes the downstream core can execute
   function automatic logic opcode_known(input logic [7:0] op);
      return (op == OPCODE_ECHO) || (op == OPCODE_ADD) ||
             (op == OPCODE_MUL)  || (op == OPCODE_DIV);
   endfunction

   // States in which the parser pulls bytes from the UART
   function automatic logic state_accepts(input parser_state_t s);
      return (s == P_OPCODE) || (s == P_RSVD) || (s == P_LEN_LSB) ||
             (s == P_LEN_MSB) || (s == P_PAYLOAD) || (s == P_DROP);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pkt_rx_parser.sv
//------------------------------------------------------------------------------
// pkt_rx_parser
//   Decodes the 4-byte packet header from the UART byte stream, presents it
//   on a header handshake, then packs the payload into little-endian words
//   with a byte-keep mask and last flag. Malformed headers pulse err_o.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pkt_rx_parser
   import config_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int WORD_BYTES = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [DATA_WIDTH-1:0]            rx_data_i,
   input  logic                             rx_valid_i,
   output logic                             rx_ready_o,
   output logic [7:0]                       hdr_opcode_o,
   output logic [15:0]                      hdr_length_o,
   output logic                             hdr_valid_o,
   input  logic                             hdr_ready_i,
   output logic [WORD_BYTES*DATA_WIDTH-1:0] word_data_o,
   output logic [WORD_BYTES-1:0]            word_keep_o,
   output logic                             word_last_o,
   output logic                             word_valid_o,
   input  logic                             word_ready_i,
   output logic                             err_o
);

   localparam int                WORD_W    = WORD_BYTES * DATA_WIDTH;
   localparam int                LANE_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(WORD_BYTES - 1);
   localparam logic [15:0]       HDR_LEN   = 16'(HDR_BYTES);

   parser_state_t       state_q, state_d;
   logic [7:0]          opcode_q, opcode_d;
   logic [15:0]         length_q, length_d;
   logic [15:0]         remaining_q, remaining_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic [WORD_W-1:0]   data_q, data_d;
   logic [WORD_BYTES-1:0] keep_q, keep_d;
   logic                last_q, last_d;
   logic                err_q, err_d;
   logic                rx_ready_q, rx_ready_d;
   logic                hdr_valid_q, hdr_valid_d;
   logic                word_valid_q, word_valid_d;

   logic                rx_fire;
   logic                hdr_fire;
   logic                word_fire;
   logic [15:0]         len_full;

   assign rx_fire   = rx_valid_i && rx_ready_q;
   assign hdr_fire  = hdr_valid_q && hdr_ready_i;
   assign word_fire = word_valid_q && word_ready_i;
   assign len_full  = {rx_data_i[7:0], length_q[7:0]};

   // Next-state, header decode and payload lane packing
   always_comb begin
      state_d     = state_q;
      opcode_d    = opcode_q;
      length_d    = length_q;
      remaining_d = remaining_q;
      lane_d      = lane_q;
      data_d      = data_q;
      keep_d      = keep_q;
      last_d      = last_q;
      err_d       = 1'b0;

      case (state_q)
         P_OPCODE: begin
            if (rx_fire) begin
               opcode_d = rx_data_i[7:0];
               state_d  = P_RSVD;
            end
         end
         P_RSVD: begin
            if (rx_fire) state_d = P_LEN_LSB;
         end
         P_LEN_LSB: begin
            if (rx_fire) begin
               length_d[7:0] = rx_data_i[7:0];
               state_d       = P_LEN_MSB;
            end
         end
         P_LEN_MSB: begin
            if (rx_fire) begin
               length_d = len_full;
               if (len_full < HDR_LEN) begin
                  // Too short to even hold its own header: nothing to skip
                  err_d       = 1'b1;
                  remaining_d = '0;
                  state_d     = P_OPCODE;
               end else if (!opcode_known(opcode_q)) begin
                  // Unknown opcode: swallow the payload so framing survives
                  err_d       = 1'b1;
                  remaining_d = len_full - HDR_LEN;
                  state_d     = (remaining_d == '0) ? P_OPCODE : P_DROP;
               end else begin
                  remaining_d = len_full - HDR_LEN;
                  state_d     = P_HDR;
               end
            end
         end
         P_HDR: begin
            if (hdr_fire) state_d = (remaining_q == '0) ? P_OPCODE : P_PAYLOAD;
         end
         P_PAYLOAD: begin
            if (rx_fire) begin
               data_d[lane_q*DATA_WIDTH +: DATA_WIDTH] = rx_data_i;
               keep_d[lane_q] = 1'b1;
               remaining_d    = remaining_q - 16'd1;
               lane_d         = lane_q + LANE_W'(1);
               last_d         = (remaining_d == '0);
               if ((lane_q == LANE_LAST) || (remaining_d == '0)) state_d = P_WORD;
            end
         end
         P_WORD: begin
            if (word_fire) begin
               // Clearing here keeps unused lanes of a short last word at zero
               data_d  = '0;
               keep_d  = '0;
               lane_d  = '0;
               last_d  = 1'b0;
               state_d = last_q ? P_OPCODE : P_PAYLOAD;
            end
         end
         P_DROP: begin
            if (rx_fire) begin
               remaining_d = remaining_q - 16'd1;
               if (remaining_d == '0) state_d = P_OPCODE;
            end
         end
         default: state_d = P_OPCODE;
      endcase

      rx_ready_d   = state_accepts(state_d);
      hdr_valid_d  = (state_d == P_HDR);
      word_valid_d = (state_d == P_WORD);
   end

   // State and datapath registers; handshake outputs are registered decodes
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= P_OPCODE;
         opcode_q     <= '0;
         length_q     <= '0;
         remaining_q  <= '0;
         lane_q       <= '0;
         data_q       <= '0;
         keep_q       <= '0;
         last_q       <= 1'b0;
         err_q        <= 1'b0;
         rx_ready_q   <= 1'b0;
         hdr_valid_q  <= 1'b0;
         word_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         opcode_q     <= opcode_d;
         length_q     <= length_d;
         remaining_q  <= remaining_d;
         lane_q       <= lane_d;
         data_q       <= data_d;
         keep_q       <= keep_d;
         last_q       <= last_d;
         err_q        <= err_d;
         rx_ready_q   <= rx_ready_d;
         hdr_valid_q  <= hdr_valid_d;
         word_valid_q <= word_valid_d;
      end
   end

   assign rx_ready_o   = rx_ready_q;
   assign hdr_opcode_o = opcode_q;
   assign hdr_length_o = length_q;
   assign hdr_valid_o  = hdr_valid_q;
   assign word_data_o  = data_q;
   assign word_keep_o  = keep_q;
   assign word_last_o  = last_q;
   assign word_valid_o = word_valid_q;
   assign err_o        = err_q;

endmodule

`default_nettype wire
